pipeline_ctrl: RTL and testbench

Pipeline sequencing and hazard controller for the 5-stage core (IF, ID, EX, MEM, WB, eight 3-bit-addressed registers). It produces per-stage enable and flush strobes from four inputs: load-use hazards in ID, taken branches resolved in EX, memory-stage wait states, and retirement of a halt instruction. It sits beside the forwarding unit, which resolves every RAW hazard except load-use. It also sequences the pipeline fill after reset and keeps a saturating stall-cycle counter.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pipeline_ctrl_load_use.sv | 21 ++
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control path.
package pipeline_pkg;

    localparam int REG_ADDR_W = 3;

    // Bubble instruction loaded by the stage registers on a flush (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_HALT     = 3'd3,
        ST_ERROR    = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard detection: a load in EX writing a register the ID instruction reads.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_regwrite,
    output logic                  hazard
);

    // r0 is an ordinary register in this core, so no zero-register exclusion.
    always_comb begin
        hazard = ex_is_load & ex_regwrite &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing and hazard controller: stage enables/flushes, fill after
// reset, memory wait tracking with timeout, halt/error terminal states, stall counter.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_regwrite,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  wb_halt,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_flush,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  err,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int IW = $clog2(INIT_CYCLES + 1);

    ctrl_state_t   state_q, state_d;
    logic [IW-1:0] init_cnt;
    logic [7:0]    wait_cnt;
    logic          hazard;
    logic          mem_busy;

    load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_regwrite (ex_regwrite),
        .hazard      (hazard)
    );

    assign mem_busy = mem_req & ~mem_ready;
    assign state    = state_q;
    assign halted   = (state_q == ST_HALT);
    assign err      = (state_q == ST_ERROR);

    // Next state and per-stage strobes; RUN and MEM_WAIT share the same strobe rules.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                {ifid_en, idex_en, exmem_en, memwb_en}  = 4'b1111;
                {ifid_flush, idex_flush, memwb_flush}   = 3'b111;
                if (init_cnt == IW'(INIT_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    // Freeze everything up to EX/MEM; WB drains into a bubble.
                    memwb_en    = 1'b1;
                    memwb_flush = 1'b1;
                end else if (ex_branch_taken) begin
                    // Squash the two younger instructions; a coincident load-use is moot.
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hazard) begin
                    // Hold IF/ID one cycle and send a bubble into EX.
                    {idex_en, exmem_en, memwb_en} = 3'b111;
                    idex_flush = 1'b1;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                end
                if (wb_halt)
                    state_d = ST_HALT;
                else if (state_q == ST_RUN) begin
                    if (mem_busy) state_d = ST_MEM_WAIT;
                end else if (!mem_busy)
                    state_d = ST_RUN;
                else if (wait_cnt == 8'(MEM_TIMEOUT - 1))
                    state_d = ST_ERROR;
            end
            default: ;  // HALT / ERROR: everything off until reset
        endcase
    end

    // State register and fill/wait counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && init_cnt != IW'(INIT_CYCLES - 1))
                init_cnt <= init_cnt + IW'(1);
            if (state_q != ST_MEM_WAIT)
                wait_cnt <= '0;
            else if (mem_busy)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Saturating count of cycles the PC was held while the pipeline was live.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_en &&
                 stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_is_load, ex_regwrite, ex_branch_taken;
    logic mem_req, mem_ready, wb_halt;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush, halted, err;
    logic [2:0] state;
    logic [CW-1:0] stall_count;

    pipeline_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .memwb_flush(memwb_flush), .state(state),
        .halted(halted), .err(err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, memwb_f}
    localparam logic [7:0] S_INIT = 8'b0111_1111;
    localparam logic [7:0] S_ALL  = 8'b1111_1000;
    localparam logic [7:0] S_FRZ  = 8'b0000_1001;
    localparam logic [7:0] S_BR   = 8'b1111_1110;
    localparam logic [7:0] S_LU   = 8'b0011_1010;
    localparam logic [7:0] S_OFF  = 8'b0000_0000;

    typedef struct {
        logic [7:0]    str;
        logic [2:0]    st;
        logic          h;
        logic          e;
        logic [CW-1:0] sc;
        int            id;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int checks = 0;
    int passed = 0;
    int vec_id = 0;

    task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s vec=%0d actual=%b required=%b", name, id, act, exp);
    endtask

    // Monitor: every presented cycle with a pending expectation is compared.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            check("strobes", mx.id,
                  {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush},
                  mx.str);
            check("state", mx.id, {5'd0, state}, {5'd0, mx.st});
            check("halted_err", mx.id, {6'd0, halted, err}, {6'd0, mx.h, mx.e});
            check("stall_count", mx.id, 8'(stall_count), 8'(mx.sc));
        end
    end

    // Drive one cycle of inputs (just after posedge) and queue its expected outputs.
    task automatic cyc(input logic rst,
                       input logic [2:0] rs1, input logic u1, input logic [2:0] rs2, input logic u2,
                       input logic [2:0] rd, input logic ld, input logic rw, input logic br,
                       input logic mreq, input logic mrdy, input logic halt,
                       input logic [7:0] es, input logic [2:0] est, input logic eh, input logic ee,
                       input logic [CW-1:0] esc);
        exp_t x;
        rst_n = rst; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_rd = rd; ex_is_load = ld; ex_regwrite = rw; ex_branch_taken = br;
        mem_req = mreq; mem_ready = mrdy; wb_halt = halt;
        x.str = es; x.st = est; x.h = eh; x.e = ee; x.sc = esc; x.id = vec_id;
        q.push_back(x);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] es, input logic [2:0] est, input logic eh,
                        input logic ee, input logic [CW-1:0] esc);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, est, eh, ee, esc);
    endtask

    initial begin
        rst_n = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_is_load = 0; ex_regwrite = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0; wb_halt = 0;
        repeat (2) @(posedge clk);
        #1;
        // Fill after reset: two INIT cycles, then RUN
        idle(S_INIT, 0, 0, 0, 0);
        idle(S_INIT, 0, 0, 0, 0);
        idle(S_ALL, 1, 0, 0, 0);
        // Load-use on rs2, one bubble, one stall counted
        cyc(1, 5, 1, 3, 1, 3, 1, 1, 0, 0, 0, 0, S_LU, 1, 0, 0, 0);
        idle(S_ALL, 1, 0, 0, 1);
        // Load-use through r0 on rs1
        cyc(1, 0, 1, 6, 0, 0, 1, 1, 0, 0, 0, 0, S_LU, 1, 0, 0, 1);
        idle(S_ALL, 1, 0, 0, 2);
        // Matching address but rs2 unused / load not writing: no hazard
        cyc(1, 1, 0, 3, 0, 3, 1, 1, 0, 0, 0, 0, S_ALL, 1, 0, 0, 2);
        cyc(1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, S_ALL, 1, 0, 0, 2);
        // Branch overrides coincident load-use, no stall
        cyc(1, 5, 1, 3, 1, 3, 1, 1, 1, 0, 0, 0, S_BR, 1, 0, 0, 2);
        idle(S_ALL, 1, 0, 0, 2);
        // Three busy cycles then release
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ, 1, 0, 0, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ, 2, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ, 2, 0, 0, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, S_ALL, 2, 0, 0, 5);
        idle(S_ALL, 1, 0, 0, 5);
        // One busy cycle, held branch takes effect on release
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, S_FRZ, 1, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, S_BR, 2, 0, 0, 6);
        idle(S_ALL, 1, 0, 0, 6);
        // Halt retires: outputs normal this cycle, HALT next, dead until reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_ALL, 1, 0, 0, 6);
        idle(S_OFF, 3, 1, 0, 6);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, S_OFF, 3, 1, 0, 6);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_OFF, 3, 1, 0, 6);
        idle(S_INIT, 0, 0, 0, 0);
        idle(S_INIT, 0, 0, 0, 0);
        idle(S_ALL, 1, 0, 0, 0);
        // Memory timeout (4): ERROR after 5 busy cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ, 2, 0, 0, CW'(i));
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_OFF, 4, 0, 1, 5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, S_OFF, 4, 0, 1, 5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_OFF, 4, 0, 1, 5);
        idle(S_INIT, 0, 0, 0, 0);
        idle(S_INIT, 0, 0, 0, 0);
        idle(S_ALL, 1, 0, 0, 0);
        // Back-to-back load-use: stall_count saturates at 7
        for (int i = 0; i < 9; i++)
            cyc(1, 2, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, S_LU, 1, 0, 0, CW'((i < 7) ? i : 7));
        idle(S_ALL, 1, 0, 0, 7);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
